// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-back FIFO, registered commit stage and RAW scoreboard for the 8x16 register file.
// Optional macro WB_FWD_EN adds forwarding of pending write data to both source operands.
module regfile_wb_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [3:0]  wb_rd,
  input  logic [15:0] wb_data,
  input  logic        rsv_valid,
  output logic        rsv_ready,
  input  logic [3:0]  rsv_rd,
  input  logic [3:0]  ReadA,
  input  logic [3:0]  ReadB,
  output logic        hazA,
  output logic        hazB,
  output logic        fwdA_valid,
  output logic        fwdB_valid,
  output logic [15:0] fwdA,
  output logic [15:0] fwdB,
  output logic        WE_R,
  output logic [3:0]  WrReg_Rd,
  output logic [15:0] InData_R
);
  localparam int AW = $clog2(DEPTH);
  logic [3:0]  memRd [DEPTH];
  logic [15:0] memData [DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic [2:0]  cnt [8];
  logic [7:0]  inc, dec;
  logic        push, pop, rsvInc, rawHazA, rawHazB;
  assign wb_ready = !(wrPtr[AW] != rdPtr[AW] && wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign push = wb_valid & wb_ready;
  assign pop = wrPtr != rdPtr;
  assign rsv_ready = rsv_rd[3] || cnt[rsv_rd[2:0]] != 3'd7;
  assign rsvInc = rsv_valid & rsv_ready & ~rsv_rd[3];
  assign rawHazA = !ReadA[3] && cnt[ReadA[2:0]] != 3'd0;
  assign rawHazB = !ReadB[3] && cnt[ReadB[2:0]] != 3'd0;
  always_comb begin
    inc = rsvInc ? 8'd1 << rsv_rd[2:0] : 8'd0;
    dec = WE_R ? 8'd1 << WrReg_Rd[2:0] : 8'd0;
  end
  always_ff @(posedge clk)
    if (push) begin
      memRd[wrPtr[AW-1:0]] <= wb_rd;
      memData[wrPtr[AW-1:0]] <= wb_data;
    end
  // Invalid destinations still drain through the commit stage, just without a write enable.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      WE_R <= 1'b0;
      WrReg_Rd <= '0;
      InData_R <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      WE_R <= pop && !memRd[rdPtr[AW-1:0]][3];
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
        WrReg_Rd <= memRd[rdPtr[AW-1:0]];
        InData_R <= memData[rdPtr[AW-1:0]];
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int r = 0; r < 8; r++) cnt[r] <= '0;
    else for (int r = 0; r < 8; r++)
      cnt[r] <= inc[r] == dec[r] ? cnt[r] : inc[r] ? cnt[r] + 3'd1 : cnt[r] == 3'd0 ? 3'd0 : cnt[r] - 3'd1;
`ifdef WB_FWD_EN
  logic [AW:0] count;
  assign count = wrPtr - rdPtr;
  // Forwarding is safe only when every outstanding reservation is already sitting in the pipeline.
  function automatic logic [16:0] fwdLookup(input logic [3:0] src);
    logic [3:0]    n;
    logic [15:0]   d;
    logic [AW-1:0] idx;
    n = {3'd0, WE_R && WrReg_Rd == src};
    d = InData_R;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr[AW-1:0] + AW'(i);
      if ((AW+1)'(i) < count && memRd[idx] == src) begin
        n = n + 4'd1;
        d = memData[idx];
      end
    end
    return (!src[3] && cnt[src[2:0]] != 3'd0 && n == {1'b0, cnt[src[2:0]]}) ? {1'b1, d} : 17'd0;
  endfunction
  always_comb begin
    {fwdA_valid, fwdA} = fwdLookup(ReadA);
    {fwdB_valid, fwdB} = fwdLookup(ReadB);
  end
  assign hazA = rawHazA & ~fwdA_valid;
  assign hazB = rawHazB & ~fwdB_valid;
`else
  assign fwdA_valid = 1'b0;
  assign fwdB_valid = 1'b0;
  assign fwdA = '0;
  assign fwdB = '0;
  assign hazA = rawHazA;
  assign hazB = rawHazB;
`endif
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: randomized and directed checks of regfile_wb_ctrl against a queue-based reference model.
module tb_regfile_wb_ctrl;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0;
  logic wb_valid = 0, rsv_valid = 0;
  logic [3:0] wb_rd = 0, rsv_rd = 0, ReadA = 0, ReadB = 0;
  logic [15:0] wb_data = 0;
  logic wb_ready, rsv_ready, hazA, hazB, fwdA_valid, fwdB_valid, WE_R;
  logic [15:0] fwdA, fwdB, InData_R;
  logic [3:0] WrReg_Rd;
  int nChecks = 0, nFail = 0;

  regfile_wb_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .rsv_valid(rsv_valid), .rsv_ready(rsv_ready), .rsv_rd(rsv_rd),
    .ReadA(ReadA), .ReadB(ReadB), .hazA(hazA), .hazB(hazB), .fwdA_valid(fwdA_valid),
    .fwdB_valid(fwdB_valid), .fwdA(fwdA), .fwdB(fwdB), .WE_R(WE_R), .WrReg_Rd(WrReg_Rd),
    .InData_R(InData_R)
  );

  always #5 clk = ~clk;

  // Reference model: pending results as a queue, the commit stage, and plain integer counters.
  logic [19:0] q[$];
  logic mWe = 0;
  logic [3:0] mRd = 0;
  logic [15:0] mData = 0;
  int mCnt[8];

  function automatic void resetModel();
    q.delete();
    mWe = 0;
    mRd = 0;
    mData = 0;
    for (int r = 0; r < 8; r++) mCnt[r] = 0;
  endfunction

  function automatic logic [16:0] expFwd(input logic [3:0] s);
    int n;
    logic [15:0] d;
`ifdef WB_FWD_EN
    if (s >= 8 || mCnt[s[2:0]] == 0) return 17'd0;
    n = (mWe && mRd == s) ? 1 : 0;
    d = mData;
    foreach (q[i]) if (q[i][19:16] == s) begin n++; d = q[i][15:0]; end
    return (n == mCnt[s[2:0]]) ? {1'b1, d} : 17'd0;
`else
    n = 0;
    d = 0;
    return {n[0], d};
`endif
  endfunction

  function automatic logic expHaz(input logic [3:0] s);
    logic [16:0] f;
    if (s >= 8 || mCnt[s[2:0]] == 0) return 1'b0;
    f = expFwd(s);
    return !f[16];
  endfunction

  task automatic tick();
    bit acc, rAcc;
    int d;
    logic [19:0] e;
    @(posedge clk);
    acc = wb_valid && q.size() < DEPTH;
    rAcc = rsv_valid && rsv_rd < 8 && mCnt[rsv_rd[2:0]] < 7;
    for (int r = 0; r < 8; r++) begin
      d = ((rAcc && rsv_rd == r) ? 1 : 0) - ((mWe && mRd == r) ? 1 : 0);
      if (d > 0) mCnt[r]++;
      else if (d < 0 && mCnt[r] > 0) mCnt[r]--;
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      mWe = e[19:16] < 8;
      mRd = e[19:16];
      mData = e[15:0];
    end else mWe = 0;
    if (acc) q.push_back({wb_rd, wb_data});
    @(negedge clk);
  endtask

  task automatic idle();
    wb_valid = 0;
    rsv_valid = 0;
  endtask

  task automatic doReset();
    idle();
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    resetModel();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    resetModel();
    #1;
    nChecks += 8;
    if (WE_R !== 1'b0) begin nFail++; $display("FAIL reset_we: got %b exp 0", WE_R); end
    if (WrReg_Rd !== 4'd0) begin nFail++; $display("FAIL reset_rd: got %h exp 0", WrReg_Rd); end
    if (InData_R !== 16'd0) begin nFail++; $display("FAIL reset_data: got %h exp 0", InData_R); end
    if (wb_ready !== 1'b1) begin nFail++; $display("FAIL reset_wb_ready: got %b exp 1", wb_ready); end
    if (rsv_ready !== 1'b1) begin nFail++; $display("FAIL reset_rsv_ready: got %b exp 1", rsv_ready); end
    if ({hazA, hazB} !== 2'b00) begin nFail++; $display("FAIL reset_haz: got %b exp 00", {hazA, hazB}); end
    if ({fwdA_valid, fwdB_valid} !== 2'b00) begin nFail++; $display("FAIL reset_fwd_valid: got %b exp 00", {fwdA_valid, fwdB_valid}); end
    if ({fwdA, fwdB} !== 32'd0) begin nFail++; $display("FAIL reset_fwd_data: got %h exp 0", {fwdA, fwdB}); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_single_write();
    doReset();
    ReadA = 3;
    ReadB = 3;
    rsv_valid = 1; rsv_rd = 3;
    tick();
    rsv_valid = 0;
    wb_valid = 1; wb_rd = 3; wb_data = 16'hBEEF;
    #1;
    nChecks++;
    if (hazA !== 1'b1) begin nFail++; $display("FAIL single_haz_before: got %b exp 1", hazA); end
    tick();
    idle();
    #1;
    nChecks += 2;
    if (WE_R !== 1'b0) begin nFail++; $display("FAIL single_we_early: got %b exp 0", WE_R); end
    if (hazA !== expHaz(3)) begin nFail++; $display("FAIL single_haz_queued: got %b exp %b", hazA, expHaz(3)); end
    tick();
    #1;
    nChecks += 4;
    if (WE_R !== 1'b1) begin nFail++; $display("FAIL single_we: got %b exp 1", WE_R); end
    if (WrReg_Rd !== 4'd3) begin nFail++; $display("FAIL single_rd: got %h exp 3", WrReg_Rd); end
    if (InData_R !== 16'hBEEF) begin nFail++; $display("FAIL single_data: got %h exp beef", InData_R); end
`ifdef WB_FWD_EN
    if (hazA !== 1'b0) begin nFail++; $display("FAIL single_haz_commit: got %b exp 0", hazA); end
`else
    if (hazA !== 1'b1) begin nFail++; $display("FAIL single_haz_commit: got %b exp 1", hazA); end
`endif
    tick();
    #1;
    nChecks += 2;
    if (WE_R !== 1'b0) begin nFail++; $display("FAIL single_we_once: got %b exp 0", WE_R); end
    if (hazA !== 1'b0) begin nFail++; $display("FAIL single_haz_after: got %b exp 0", hazA); end
  endtask

  task automatic test_full();
    logic [15:0] sent[$];
    doReset();
    for (int i = 0; i < DEPTH + 2 + DEPTH + 2; i++) begin
      wb_valid = i < DEPTH + 2;
      wb_rd = 4'($urandom_range(0, 7));
      wb_data = 16'($urandom);
      #1;
      nChecks++;
      if (wb_ready !== (q.size() < DEPTH)) begin nFail++; $display("FAIL full_ready: got %b exp %b", wb_ready, q.size() < DEPTH); end
      if (WE_R === 1'b1) begin
        nChecks++;
        if (sent.size() == 0) begin nFail++; $display("FAIL full_spurious_write: got %h exp none", InData_R); end
        else if (InData_R !== sent[0]) begin nFail++; $display("FAIL full_order: got %h exp %h", InData_R, sent[0]); end
        if (sent.size() != 0) void'(sent.pop_front());
      end
      if (wb_valid && wb_ready) sent.push_back(wb_data);
      tick();
    end
    idle();
    nChecks++;
    if (sent.size() != 0) begin nFail++; $display("FAIL full_drained: got %0d left exp 0", sent.size()); end
  endtask

  task automatic test_sim_rsv_commit();
    doReset();
    ReadA = 5;
    rsv_valid = 1; rsv_rd = 5;
    tick();
    rsv_valid = 0;
    wb_valid = 1; wb_rd = 5; wb_data = 16'h5555;
    tick();
    idle();
    tick();
    rsv_valid = 1; rsv_rd = 5;
    #1;
    nChecks++;
    if (WE_R !== 1'b1) begin nFail++; $display("FAIL sim_commit_we: got %b exp 1", WE_R); end
    tick();
    idle();
    #1;
    nChecks += 2;
    if (hazA !== 1'b1) begin nFail++; $display("FAIL sim_haz: got %b exp 1", hazA); end
    if (mCnt[5] != 1) begin nFail++; $display("FAIL sim_model_cnt: got %0d exp 1", mCnt[5]); end
  endtask

  task automatic test_forward();
    doReset();
    ReadA = 2;
    ReadB = 2;
    rsv_valid = 1; rsv_rd = 2;
    tick();
    tick();
    rsv_valid = 0;
    wb_valid = 1; wb_rd = 2; wb_data = 16'h0011;
    tick();
    wb_data = 16'h0022;
    tick();
    idle();
    #1;
    nChecks += 5;
`ifdef WB_FWD_EN
    if (fwdA_valid !== 1'b1) begin nFail++; $display("FAIL fwd_valid: got %b exp 1", fwdA_valid); end
    if (fwdA !== 16'h0022) begin nFail++; $display("FAIL fwd_data: got %h exp 0022", fwdA); end
    if (hazA !== 1'b0) begin nFail++; $display("FAIL fwd_haz: got %b exp 0", hazA); end
    if (fwdB !== 16'h0022) begin nFail++; $display("FAIL fwd_data_b: got %h exp 0022", fwdB); end
`else
    if (fwdA_valid !== 1'b0) begin nFail++; $display("FAIL fwd_valid: got %b exp 0", fwdA_valid); end
    if (fwdA !== 16'h0000) begin nFail++; $display("FAIL fwd_data: got %h exp 0000", fwdA); end
    if (hazA !== 1'b1) begin nFail++; $display("FAIL fwd_haz: got %b exp 1", hazA); end
    if (hazB !== 1'b1) begin nFail++; $display("FAIL fwd_haz_b: got %b exp 1", hazB); end
`endif
    if (WE_R !== 1'b1 || InData_R !== 16'h0011) begin nFail++; $display("FAIL fwd_commit: got %b/%h exp 1/0011", WE_R, InData_R); end
  endtask

  task automatic test_invalid();
    doReset();
    ReadA = 1;
    ReadB = 9;
    rsv_valid = 1; rsv_rd = 1;
    tick();
    rsv_valid = 0;
    wb_valid = 1; wb_rd = 9; wb_data = 16'h1234;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      nChecks += 3;
      if (WE_R !== 1'b0) begin nFail++; $display("FAIL invalid_we: got %b exp 0", WE_R); end
      if (hazA !== 1'b1) begin nFail++; $display("FAIL invalid_cnt_kept: got %b exp 1", hazA); end
      if (hazB !== 1'b0) begin nFail++; $display("FAIL invalid_src_haz: got %b exp 0", hazB); end
      tick();
    end
  endtask

  task automatic test_saturate();
    doReset();
    ReadA = 4;
    rsv_valid = 1; rsv_rd = 4;
    for (int i = 0; i < 7; i++) begin
      #1;
      nChecks++;
      if (rsv_ready !== 1'b1) begin nFail++; $display("FAIL sat_ready_low: got %b exp 1 at %0d", rsv_ready, i); end
      tick();
    end
    #1;
    nChecks += 2;
    if (rsv_ready !== 1'b0) begin nFail++; $display("FAIL sat_ready: got %b exp 0", rsv_ready); end
    if (hazA !== 1'b1) begin nFail++; $display("FAIL sat_haz: got %b exp 1", hazA); end
    tick();
    rsv_rd = 9;
    #1;
    nChecks++;
    if (rsv_ready !== 1'b1) begin nFail++; $display("FAIL sat_invalid_rd_ready: got %b exp 1", rsv_ready); end
    idle();
  endtask

  task automatic test_reset_mid();
    doReset();
    ReadA = 6;
    ReadB = 6;
    rsv_valid = 1; rsv_rd = 6;
    tick(); tick(); tick();
    rsv_valid = 0;
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1; wb_rd = 6; wb_data = 16'(16'hA000 + i);
      tick();
    end
    idle();
    #1;
    nChecks += 2;
    if (WE_R !== 1'b1) begin nFail++; $display("FAIL mid_we_before: got %b exp 1", WE_R); end
    if (hazA !== expHaz(6)) begin nFail++; $display("FAIL mid_haz_before: got %b exp %b", hazA, expHaz(6)); end
    #1;
    rst_n = 0;
    resetModel();
    #1;
    nChecks += 3;
    if (WE_R !== 1'b0) begin nFail++; $display("FAIL mid_we_reset: got %b exp 0", WE_R); end
    if (wb_ready !== 1'b1) begin nFail++; $display("FAIL mid_ready_reset: got %b exp 1", wb_ready); end
    if ({hazA, hazB} !== 2'b00) begin nFail++; $display("FAIL mid_haz_reset: got %b exp 00", {hazA, hazB}); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      nChecks++;
      if (WE_R !== 1'b0) begin nFail++; $display("FAIL mid_no_write: got %b exp 0 at %0d", WE_R, i); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [16:0] fa, fb;
    doReset();
    for (int c = 0; c < 400; c++) begin
      wb_valid = $urandom_range(0, 3) != 0;
      wb_rd = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 3));
      wb_data = 16'($urandom);
      rsv_valid = $urandom_range(0, 2) == 0;
      rsv_rd = 4'($urandom_range(0, 4));
      ReadA = 4'($urandom_range(0, 4));
      ReadB = 4'($urandom_range(0, 9));
      #1;
      fa = expFwd(ReadA);
      fb = expFwd(ReadB);
      nChecks += 9;
      if (wb_ready !== (q.size() < DEPTH)) begin nFail++; $display("FAIL rnd_wb_ready: got %b exp %b", wb_ready, q.size() < DEPTH); end
      if (rsv_ready !== (rsv_rd >= 8 || mCnt[rsv_rd[2:0]] < 7)) begin nFail++; $display("FAIL rnd_rsv_ready: got %b", rsv_ready); end
      if (WE_R !== mWe) begin nFail++; $display("FAIL rnd_we: got %b exp %b", WE_R, mWe); end
      if (hazA !== expHaz(ReadA)) begin nFail++; $display("FAIL rnd_hazA: got %b exp %b r=%0d", hazA, expHaz(ReadA), ReadA); end
      if (hazB !== expHaz(ReadB)) begin nFail++; $display("FAIL rnd_hazB: got %b exp %b r=%0d", hazB, expHaz(ReadB), ReadB); end
      if (fwdA_valid !== fa[16]) begin nFail++; $display("FAIL rnd_fwdA_valid: got %b exp %b", fwdA_valid, fa[16]); end
      if (fwdB_valid !== fb[16]) begin nFail++; $display("FAIL rnd_fwdB_valid: got %b exp %b", fwdB_valid, fb[16]); end
      if (fa[16] && fwdA !== fa[15:0]) begin nFail++; $display("FAIL rnd_fwdA: got %h exp %h", fwdA, fa[15:0]); end
      if (fb[16] && fwdB !== fb[15:0]) begin nFail++; $display("FAIL rnd_fwdB: got %h exp %h", fwdB, fb[15:0]); end
      if (mWe) begin
        nChecks++;
        if ({WrReg_Rd, InData_R} !== {mRd, mData}) begin nFail++; $display("FAIL rnd_commit: got %h/%h exp %h/%h", WrReg_Rd, InData_R, mRd, mData); end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_full();
    test_sim_rsv_commit();
    test_forward();
    test_invalid();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
